seq_addmul_unit: RTL and testbench

//   Parametrised add/multiply unit with a valid/ready handshake on operands and results.

---
 rtl/seq_addmul_pkg.sv | 37 +++
 rtl/seq_addmul_unit_mul_core.sv | 65 ++++++
 rtl/seq_addmul_unit.sv | 162 ++++++++++++++++
 tb/tb_seq_addmul_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seq_addmul_pkg.sv
// Shared definitions for seq_addmul_unit: op encodings, FSM states and op decode.
// The MAC/ACLR ops exist only when the unit is built with SEQ_ADDMUL_MAC_EN.
package seq_addmul_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_MAC  = 2'b10;
  localparam logic [1:0] OP_ACLR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ADD_S,
    MUL_S,
    DONE
  } state_e;

  // Decoded operation kind, after folding illegal encodings onto MUL.
  typedef enum logic [1:0] {
    KindAdd,
    KindMul,
    KindMac,
    KindAclr
  } op_kind_e;

  // Without the accumulator, any op other than ADD behaves as a plain multiply.
  function automatic op_kind_e decode_op(input logic [1:0] op, input logic mac_en);
    op_kind_e kind;
    unique case (op)
      OP_ADD:  kind = KindAdd;
      OP_MUL:  kind = KindMul;
      OP_MAC:  kind = mac_en ? KindMac : KindMul;
      default: kind = mac_en ? KindAclr : KindMul;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/seq_addmul_unit_mul_core.sv
// Iterative shift-add multiplier: one partial product per step.
// load_i captures the operands; each step_i retires one multiplier bit.
// prod_o already includes the effect of the current step so the caller can
// register the final product on the same edge as the last step.
module shift_add_mul_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] prod_o,
  output logic               done_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  // Load operands or perform one shift-add step.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      prod_d   = '0;
      cnt_d    = CntW'(WIDTH);
    end else if (step_i) begin
      if (mplier_q[0]) begin
        prod_d = prod_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CntW'(1);
    end
  end

  // Datapath registers, cleared by reset so an aborted multiply leaves no residue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  // The step taken while cnt is 1 is the last one.
  assign prod_o = prod_d;
  assign done_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/seq_addmul_unit.sv
// Add/multiply unit with valid/ready handshakes on operands and results.
// ADD completes in one working cycle, MUL/MAC run WIDTH shift-add steps.
// Build option: define SEQ_ADDMUL_MAC_EN to add the accumulator (MAC and ACLR ops);
// otherwise op encodings 10/11 decode as MUL.
module seq_addmul_unit
  import seq_addmul_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

`ifdef SEQ_ADDMUL_MAC_EN
  localparam logic MacEn = 1'b1;
`else
  localparam logic MacEn = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  op_kind_e           op_kind;
  logic               core_load;
  logic               core_step;
  logic [2*WIDTH-1:0] core_prod;
  logic               core_done;

`ifdef SEQ_ADDMUL_MAC_EN
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               mac_q, mac_d;
`endif

  // Decode the presented op for the current build.
  always_comb begin
    op_kind = decode_op(op, MacEn);
  end

  shift_add_mul_core #(
    .WIDTH (WIDTH)
  ) u_mul_core (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .load_i (core_load),
    .step_i (core_step),
    .a_i    (a),
    .b_i    (b),
    .prod_o (core_prod),
    .done_o (core_done)
  );

  // FSM next state, operand capture, result and accumulator update.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    core_load = 1'b0;
    core_step = 1'b0;
`ifdef SEQ_ADDMUL_MAC_EN
    acc_d     = acc_q;
    mac_d     = mac_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d = a;
          b_d = b;
          unique case (op_kind)
            KindAdd: begin
              state_d = ADD_S;
            end
            KindAclr: begin
              state_d  = DONE;
              result_d = '0;
`ifdef SEQ_ADDMUL_MAC_EN
              acc_d    = '0;
`endif
            end
            default: begin
              state_d   = MUL_S;
              core_load = 1'b1;
`ifdef SEQ_ADDMUL_MAC_EN
              mac_d     = (op_kind == KindMac);
`endif
            end
          endcase
        end
      end
      ADD_S: begin
        // Zero-extended add keeps the carry in bit WIDTH.
        result_d = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
        state_d  = DONE;
      end
      MUL_S: begin
        core_step = 1'b1;
        if (core_done) begin
          state_d  = DONE;
          result_d = core_prod;
`ifdef SEQ_ADDMUL_MAC_EN
          if (mac_q) begin
            acc_d    = acc_q + core_prod;
            result_d = acc_d;
          end
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, captured operands and the result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

`ifdef SEQ_ADDMUL_MAC_EN
  // Accumulator and the MAC flag of the operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      mac_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      mac_q <= mac_d;
    end
  end
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_seq_addmul_unit.sv
// Self-checking bench for seq_addmul_unit: directed cases plus a random regression
// checked against an arithmetic reference model (honours SEQ_ADDMUL_MAC_EN).
module tb_seq_addmul_unit;
  import seq_addmul_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned RW = 2 * W;
  localparam longint      Mask = (64'd1 << RW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          in_ready;
  logic          out_valid;
  logic          busy;
  logic [RW-1:0] result;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint model_acc = 0;

  always #5 clk = ~clk;

  seq_addmul_unit #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: result value and cycles from the accept cycle to the first out_valid cycle.
  task automatic model(input logic [1:0] o, input longint x, input longint y,
                       output longint res, output int lat);
`ifdef SEQ_ADDMUL_MAC_EN
    case (o)
      2'd0: begin res = x + y; lat = 2; end
      2'd1: begin res = x * y; lat = W + 1; end
      2'd2: begin
        model_acc = (model_acc + x * y) & Mask;
        res = model_acc;
        lat = W + 1;
      end
      default: begin model_acc = 0; res = 0; lat = 1; end
    endcase
`else
    if (o == 2'd0) begin
      res = x + y;
      lat = 2;
    end else begin
      res = x * y;
      lat = W + 1;
    end
`endif
  endtask

  // Called #1 after a rising edge with the unit idle.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int hold, input string tag);
    longint        er;
    int            el;
    int            lat;
    logic [RW-1:0] held;
    model(o, longint'(x), longint'(y), er, el);
    in_valid  = 1'b1;
    op        = o;
    a         = x;
    b         = y;
    out_ready = 1'b0;
    check({tag, "/in_ready_before"}, in_ready, 1);
    @(posedge clk); #1;
    // Scramble inputs after accept; the unit must ignore them.
    in_valid = 1'b0;
    op       = 2'($urandom_range(0, 3));
    a        = W'($urandom_range(0, (1 << W) - 1));
    b        = W'($urandom_range(0, (1 << W) - 1));
    lat = 1;
    while (!out_valid && lat < 64) begin
      check({tag, "/in_ready_busy"}, in_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/latency"}, lat, el);
    check({tag, "/result"}, result, er);
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "/hold_valid"}, out_valid, 1);
      check({tag, "/hold_result"}, result, held);
      check({tag, "/hold_in_ready"}, in_ready, 0);
      check({tag, "/hold_busy"}, busy, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "/post_valid"}, out_valid, 0);
    check({tag, "/post_in_ready"}, in_ready, 1);
    check({tag, "/idle_result"}, result, held);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset/in_ready", in_ready, 1);
    check("reset/out_valid", out_valid, 0);
    check("reset/busy", busy, 0);
    check("reset/result", result, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(OP_ADD, 4'd7, 4'd9, 0, "add_7_9");
    check("add_7_9/const", result, 8'h10);
    run_op(OP_MUL, 4'd15, 4'd15, 0, "mul_15_15");
    check("mul_15_15/const", result, 8'hE1);
    run_op(OP_MUL, 4'd0, 4'd13, 0, "mul_0_13");
    run_op(OP_MUL, 4'd6, 4'd7, 4, "mul_bp");
    check("mul_bp/const", result, 8'h2A);

    // Abort a multiply in its second MUL_S cycle.
    in_valid = 1'b1;
    op       = OP_MUL;
    a        = 4'd5;
    b        = 4'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("abort/busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort/in_ready", in_ready, 1);
    check("abort/out_valid", out_valid, 0);
    check("abort/busy", busy, 0);
    check("abort/result", result, 0);
    model_acc = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(OP_ADD, 4'd1, 4'd1, 0, "add_after_rst");
    check("add_after_rst/const", result, 8'h02);

`ifdef SEQ_ADDMUL_MAC_EN
    run_op(OP_ACLR, 4'd9, 4'd9, 0, "aclr");
    check("aclr/const", result, 0);
    run_op(OP_MAC, 4'd3, 4'd4, 0, "mac_3_4");
    check("mac_3_4/const", result, 12);
    run_op(OP_MAC, 4'd5, 4'd6, 1, "mac_5_6");
    check("mac_5_6/const", result, 42);
    run_op(OP_MUL, 4'd2, 4'd2, 0, "mul_2_2");
    check("mul_2_2/const", result, 4);
    run_op(OP_MAC, 4'd1, 4'd1, 0, "mac_1_1");
    check("mac_1_1/const", result, 43);
`else
    run_op(2'b10, 4'd3, 4'd5, 0, "op10_as_mul");
    check("op10_as_mul/const", result, 15);
    run_op(2'b11, 4'd2, 4'd7, 0, "op11_as_mul");
`endif

    for (int i = 0; i < 60; i++) begin
      run_op(2'($urandom_range(0, 3)), W'($urandom_range(0, (1 << W) - 1)),
             W'($urandom_range(0, (1 << W) - 1)), $urandom_range(0, 2), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
